// File: rtl/soc_event_tracer.sv
// soc_event_tracer
//   Change-triggered capture of a masked debug probe bus. When any masked-in
//   probe bit differs from its previous sample, {probe_in, ts} is pushed into
//   a first-word-fall-through FIFO that is drained over a valid/ready port.
//
//   Optional feature: define SOC_TRACE_TS_EN to build the free-running
//   timestamp counter and per-entry timestamp storage. When it is undefined,
//   evt_ts is tied to 0 and everything else behaves the same.
//
// Ports
//   clk, resetn     clock, asynchronous active-low reset
//   enable          capture and timestamp counting active
//   clear           synchronous flush (one-cycle pulse), wins over push/pop
//   probe_in, mask  observed signals; mask bit 1 = participates in detection
//   evt_valid/ready FIFO head handshake
//   evt_data/ts     head entry (0 while empty)
//   level           FIFO occupancy
//   overflow        sticky drop flag
//   drop_cnt        dropped events, saturating at 255
module soc_event_tracer #(
    parameter int PROBE_W = 34,
    parameter int DEPTH   = 16,
    parameter int TS_W    = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [PROBE_W-1:0]       probe_in,
    input  logic [PROBE_W-1:0]       mask,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [PROBE_W-1:0]       evt_data,
    output logic [TS_W-1:0]          evt_ts,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [PROBE_W-1:0] probe_q;
    logic               primed;
    logic [AW:0]        wr_ptr, rd_ptr;
    logic [PROBE_W-1:0] data_mem [DEPTH];
    logic               empty, full, hit, pop, push_ok, drop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign hit     = enable & primed & (|((probe_in ^ probe_q) & mask));
    assign pop     = ~empty & evt_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = hit & (~full | pop);
    assign drop    = hit & full & ~pop;

    assign evt_valid = ~empty;
    assign level     = wr_ptr - rd_ptr;
    assign evt_data  = empty ? '0 : data_mem[rd_ptr[AW-1:0]];

    // probe_q follows probe_in every cycle; clear reloads it the same way, so
    // only primed needs special handling to suppress the first comparison.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            probe_q <= '0;
            primed  <= 1'b0;
        end else begin
            probe_q <= probe_in;
            primed  <= ~clear;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clear) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Storage needs no reset: the read side is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) data_mem[wr_ptr[AW-1:0]] <= probe_in;
    end

`ifdef SOC_TRACE_TS_EN
    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] ts_mem [DEPTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     ts <= '0;
        else if (clear)  ts <= '0;
        else if (enable) ts <= ts + TS_W'(1);
    end

    // Entry takes the pre-increment count of the capturing cycle.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) ts_mem[wr_ptr[AW-1:0]] <= ts;
    end

    assign evt_ts = empty ? '0 : ts_mem[rd_ptr[AW-1:0]];
`else
    assign evt_ts = '0;
`endif

endmodule

// File: tb/tb_soc_event_tracer.sv
module tb_soc_event_tracer;
    localparam int PW    = 34;
    localparam int DEPTH = 16;
    localparam int TSW   = 4;

    logic                       clk = 1'b0;
    logic                       resetn = 1'b0;
    logic                       enable = 1'b0;
    logic                       clear = 1'b0;
    logic                       evt_ready = 1'b0;
    logic [PW-1:0]              probe_in = '0;
    logic [PW-1:0]              mask = '1;
    logic                       evt_valid;
    logic [PW-1:0]              evt_data;
    logic [TSW-1:0]             evt_ts;
    logic [$clog2(DEPTH):0]     level;
    logic                       overflow;
    logic [7:0]                 drop_cnt;

    soc_event_tracer #(.PROBE_W(PW), .DEPTH(DEPTH), .TS_W(TSW)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .clear(clear),
        .probe_in(probe_in), .mask(mask),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_data(evt_data), .evt_ts(evt_ts),
        .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [PW-1:0] d; int ts; } ent_t;

    // Reference model: a queue of captured events plus scalar bookkeeping.
    ent_t           mq[$];
    int             mts;
    logic [PW-1:0]  mprev;
    bit             mprimed, movf;
    int             mdrops;
    ent_t           plog[$];     // events observed leaving the DUT
    int             nvec = 0, nerr = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_ts(int t);
`ifdef SOC_TRACE_TS_EN
        return t;
`else
        return 0;
`endif
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mq.delete(); mts = 0; mprev = '0; mprimed = 0; movf = 0; mdrops = 0;
        end else if (clear) begin
            mq.delete(); mts = 0; mprev = probe_in; mprimed = 0; movf = 0; mdrops = 0;
        end else begin
            if (mq.size() > 0 && evt_ready) void'(mq.pop_front());
            if (enable && mprimed && (((probe_in ^ mprev) & mask) != '0)) begin
                if (mq.size() < DEPTH) mq.push_back('{probe_in, mts});
                else begin
                    movf = 1;
                    if (mdrops < 255) mdrops++;
                end
            end
            if (enable) mts = (mts + 1) % (1 << TSW);
            mprimed = 1;
            mprev = probe_in;
        end
    end

    // Every-cycle compare, on the falling edge.
    always @(negedge clk) begin
        if (resetn) begin
            chk("valid", evt_valid, mq.size() > 0);
            chk("level", level, mq.size());
            chk("overflow", overflow, movf);
            chk("drop_cnt", drop_cnt, mdrops);
            if (mq.size() > 0) begin
                chk("evt_data", evt_data, mq[0].d);
                chk("evt_ts", evt_ts, exp_ts(mq[0].ts));
            end
            if (evt_valid && evt_ready) plog.push_back('{evt_data, int'(evt_ts)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_to(logic [PW-1:0] p, logic [PW-1:0] m, logic rdy);
        resetn = 1'b0; probe_in = p; mask = m; evt_ready = rdy; enable = 1'b1; clear = 1'b0;
        tick();
        resetn = 1'b1;
        plog.delete();
    endtask

    initial begin
        // reset values
        #3;
        chk("rst_valid", evt_valid, 0);
        chk("rst_data", evt_data, 0);
        chk("rst_ts", evt_ts, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_cnt, 0);

        // single change at ts=5
        reset_to('0, '1, 1'b1);
        repeat (5) tick();
        probe_in = 34'h1;
        repeat (6) tick();
        chk("t1_count", plog.size(), 1);
        if (plog.size() > 0) begin
            chk("t1_data", plog[0].d, 34'h1);
            chk("t1_ts", plog[0].ts, exp_ts(5));
        end

        // nonzero probe at reset release is suppressed by priming
        reset_to(34'h3FF, '1, 1'b1);
        repeat (5) tick();
        chk("t2_count", plog.size(), 0);
        chk("t2_level", level, 0);

        // masking: bit 4 ignored, bit 0 triggers; mask change alone is silent
        reset_to('0, 34'h1, 1'b1);
        repeat (2) tick();
        probe_in = 34'h10;
        repeat (2) tick();
        probe_in = 34'h11;
        repeat (3) tick();
        chk("t3_count", plog.size(), 1);
        if (plog.size() > 0) chk("t3_data", plog[0].d, 34'h11);
        mask = '1;
        repeat (3) tick();
        chk("t3_maskchg", plog.size(), 1);

        // overflow: 20 changes into 16 entries, then drain in order
        reset_to('0, '1, 1'b0);
        repeat (2) tick();
        for (int i = 1; i <= 20; i++) begin
            probe_in = PW'(i);
            tick();
        end
        chk("t4_level", level, 16);
        chk("t4_ovf", overflow, 1);
        chk("t4_drop", drop_cnt, 4);
        evt_ready = 1'b1;
        repeat (20) tick();
        chk("t4_drained", plog.size(), 16);
        for (int i = 0; i < plog.size() && i < 16; i++)
            chk("t4_order", plog[i].d, 64'(i + 1));

        // full with simultaneous push and pop
        reset_to('0, '1, 1'b0);
        repeat (2) tick();
        for (int i = 1; i <= 16; i++) begin
            probe_in = PW'(i);
            tick();
        end
        chk("t5_full", level, 16);
        evt_ready = 1'b1;
        probe_in = 34'd17;
        tick();
        evt_ready = 1'b0;
        chk("t5_level", level, 16);
        chk("t5_drop", drop_cnt, 0);
        chk("t5_ovf", overflow, 0);

        // clear with level=7 and overflow=1
        probe_in = 34'd18; tick();
        probe_in = 34'd19; tick();
        chk("t6_ovf_pre", overflow, 1);
        chk("t6_drop_pre", drop_cnt, 2);
        evt_ready = 1'b1;
        repeat (9) tick();
        evt_ready = 1'b0;
        chk("t6_level_pre", level, 7);
        clear = 1'b1;
        probe_in = 34'h5A5;
        tick();
        clear = 1'b0;
        chk("t6_level", level, 0);
        chk("t6_ovf", overflow, 0);
        chk("t6_drop", drop_cnt, 0);
        chk("t6_valid", evt_valid, 0);
        probe_in = 34'h5A6;
        tick();
        chk("t6_primed", level, 0);
        probe_in = 34'h5A7;
        tick();
        chk("t6_level_post", level, 1);
        chk("t6_data_post", evt_data, 34'h5A7);
        chk("t6_ts_post", evt_ts, exp_ts(1));

        // timestamp wrap with 4-bit counter
        reset_to('0, '1, 1'b1);
        repeat (15) tick();
        probe_in = 34'h1; tick();
        probe_in = 34'h0; tick();
        repeat (3) tick();
        chk("t7_count", plog.size(), 2);
        if (plog.size() > 1) begin
            chk("t7_ts15", plog[0].ts, exp_ts(15));
            chk("t7_ts0", plog[1].ts, exp_ts(0));
        end

        // enable low: no capture, drain still works
        reset_to('0, '1, 1'b0);
        repeat (2) tick();
        probe_in = 34'h1; tick();
        probe_in = 34'h2; tick();
        enable = 1'b0;
        probe_in = 34'h3; tick();
        chk("t8_level", level, 2);
        evt_ready = 1'b1;
        repeat (3) tick();
        chk("t8_drained", plog.size(), 2);
        chk("t8_empty", level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
